// File: rtl/div_share_ctrl_if.sv
// rtl/div_share_ctrl_if.sv - request/response bundle for the shared divider
//
// Purpose: groups the two requester handshakes, the response handshake and the
// busy status of div_share_ctrl into one interface.
// Signals:
//   req0_valid/req0_ready/req0_dividend/req0_divisor  requester 0 operand pair
//   req1_valid/req1_ready/req1_dividend/req1_divisor  requester 1 operand pair
//   rsp_valid/rsp_ready                               response handshake
//   rsp_quotient/rsp_remainder/rsp_id/rsp_dbz         response payload
//   busy                                              divider not idle
// Modports: master = requesters/consumer side, slave = divider side.

interface div_share_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_id;
    logic             rsp_dbz;
    logic             busy;

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_quotient, rsp_remainder, rsp_id, rsp_dbz, busy
    );

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_quotient, rsp_remainder, rsp_id, rsp_dbz, busy
    );
endinterface

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - shared restoring divider with two-requester round-robin front end
//
// Purpose: accepts dividend/divisor pairs from two requesters (round-robin when
// both are valid), resolves one quotient bit per cycle and returns each result
// on a single response port tagged with the requester ID.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  div_share_ctrl_if.slave (requester handshakes, response, busy)

module div_share_ctrl #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    div_share_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             last_id;      // requester granted most recently
    logic             grant_id;
    logic             accept;
    logic             ready0, ready1;
    logic [WIDTH-1:0] sel_dvd, sel_dvs;

    // dvd_sr shifts dividend bits out of the top while quotient bits enter at
    // the bottom; after WIDTH iterations it holds the quotient.
    logic [WIDTH-1:0] dvd_sr;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] a_reg;        // partial remainder, always < divisor
    logic [CW-1:0]    cnt;
    logic             id_reg;
    logic             last_iter;

    logic [WIDTH:0]   a_shift, a_diff;
    logic             qbit;
    logic [WIDTH-1:0] a_next, dvd_next;

    logic [WIDTH-1:0] rsp_q_r, rsp_r_r;
    logic             rsp_id_r, rsp_dbz_r;
    logic             rsp_valid_c, busy_c;

    // Grant: a lone requester wins; with both valid the one not served last wins.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_id;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept  = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign sel_dvd = grant_id ? bus.req1_dividend : bus.req0_dividend;
    assign sel_dvs = grant_id ? bus.req1_divisor  : bus.req0_divisor;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    assign a_shift   = {a_reg, dvd_sr[WIDTH-1]};
    assign a_diff    = a_shift - {1'b0, dvs_reg};
    assign qbit      = ~a_diff[WIDTH];
    assign a_next    = qbit ? a_diff[WIDTH-1:0] : a_shift[WIDTH-1:0];
    assign dvd_next  = {dvd_sr[WIDTH-2:0], qbit};
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ready0      = 1'b0;
        ready1      = 1'b0;
        rsp_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                ready0 = bus.req0_valid && !grant_id;
                ready1 = bus.req1_valid && grant_id;
                if (accept) begin
                    state_nxt = (sel_dvs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath; response registers change only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id   <= 1'b1;
            id_reg    <= 1'b0;
            dvd_sr    <= '0;
            dvs_reg   <= '0;
            a_reg     <= '0;
            cnt       <= '0;
            rsp_q_r   <= '0;
            rsp_r_r   <= '0;
            rsp_id_r  <= 1'b0;
            rsp_dbz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_id <= grant_id;
                        id_reg  <= grant_id;
                        dvd_sr  <= sel_dvd;
                        dvs_reg <= sel_dvs;
                        a_reg   <= '0;
                        cnt     <= '0;
                        if (sel_dvs == '0) begin
                            rsp_q_r   <= '1;
                            rsp_r_r   <= '1;
                            rsp_id_r  <= grant_id;
                            rsp_dbz_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd_sr <= dvd_next;
                    a_reg  <= a_next;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        rsp_q_r   <= dvd_next;
                        rsp_r_r   <= a_next;
                        rsp_id_r  <= id_reg;
                        rsp_dbz_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready    = ready0;
    assign bus.req1_ready    = ready1;
    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.busy          = busy_c;
    assign bus.rsp_quotient  = rsp_q_r;
    assign bus.rsp_remainder = rsp_r_r;
    assign bus.rsp_id        = rsp_id_r;
    assign bus.rsp_dbz       = rsp_dbz_r;
endmodule
